// File: rtl/rd_drain_ctrl.sv
// Ping-pong read-drain controller: tracks written slots per SRAM bank and, once a
// bank is full, streams it out in slot order through a 2-entry output FIFO.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no drain active; waiting for bank next_bank to become full
// RD0   | issuing reads of bank 0, slots 0..DEPTH-1 in ascending order
// RD1   | issuing reads of bank 1, slots 0..DEPTH-1 in ascending order
module rd_drain_ctrl #(
    parameter int DEPTH = 16,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic                     wr_bank,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    output logic                     mem0_full,
    output logic                     mem1_full,
    output logic                     mem0_lock,
    output logic                     mem1_lock,
    output logic                     mem_rd_en,
    output logic                     mem_rd_bank,
    output logic [$clog2(DEPTH)-1:0] mem_rd_addr,
    input  logic [DW-1:0]            mem_rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    output logic                     wr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RD0, RD1} state_t;

    state_t          state, state_nxt;
    logic [DEPTH-1:0] bm0, bm1, bm0_nxt, bm1_nxt;
    logic            next_bank, next_bank_nxt;
    logic [AW-1:0]   rd_addr, rd_addr_nxt;
    logic            in_flight;
    logic            wr_err_q;
    logic [DW-1:0]   fifo [2];
    logic            wr_ptr, rd_ptr;
    logic [1:0]      count;

    logic            full0, full1;
    logic            wr_hit, wr_locked, wr_legal;
    logic            pop;
    logic [2:0]      occupancy;
    logic            can_issue;
    logic            rd_en_int, rd_bank_int, last_issue;

    assign full0     = &bm0;
    assign full1     = &bm1;
    assign wr_hit    = wr_bank ? bm1[wr_addr] : bm0[wr_addr];
    assign wr_locked = wr_bank ? full1 : full0;
    assign wr_legal  = wr_en && !wr_locked && !wr_hit;

    assign out_valid = rst_n && (count != 2'd0);
    assign out_data  = fifo[rd_ptr];
    assign pop       = out_valid && out_ready;

    // Words already buffered plus the one returning from the SRAM must leave room
    // for the new read; a pop this cycle frees one slot.
    assign occupancy = {1'b0, count} + {2'b0, in_flight};
    assign can_issue = occupancy < (3'd2 + {2'b0, pop});

    always_comb begin
        state_nxt     = state;
        next_bank_nxt = next_bank;
        rd_addr_nxt   = rd_addr;
        rd_en_int     = 1'b0;
        rd_bank_int   = 1'b0;
        last_issue    = 1'b0;
        case (state)
            IDLE: begin
                if (next_bank ? full1 : full0)
                    state_nxt = next_bank ? RD1 : RD0;
            end
            RD0, RD1: begin
                rd_bank_int = (state == RD1);
                if (can_issue) begin
                    rd_en_int   = 1'b1;
                    rd_addr_nxt = rd_addr + AW'(1);
                    if (rd_addr == LAST_ADDR) begin
                        last_issue    = 1'b1;
                        state_nxt     = IDLE;
                        next_bank_nxt = ~next_bank;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The bank being released is still locked this cycle, so a legal write can
    // never collide with its clear.
    always_comb begin
        bm0_nxt = bm0;
        bm1_nxt = bm1;
        if (last_issue && !rd_bank_int) bm0_nxt = '0;
        if (last_issue && rd_bank_int)  bm1_nxt = '0;
        if (wr_legal) begin
            if (wr_bank) bm1_nxt[wr_addr] = 1'b1;
            else         bm0_nxt[wr_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            next_bank <= 1'b0;
            rd_addr   <= '0;
            bm0       <= '0;
            bm1       <= '0;
            in_flight <= 1'b0;
            wr_err_q  <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
        end else begin
            state     <= state_nxt;
            next_bank <= next_bank_nxt;
            rd_addr   <= rd_addr_nxt;
            bm0       <= bm0_nxt;
            bm1       <= bm1_nxt;
            in_flight <= rd_en_int;
            wr_err_q  <= wr_en && !wr_legal;
            if (in_flight) wr_ptr <= ~wr_ptr;
            if (pop)       rd_ptr <= ~rd_ptr;
            case ({in_flight, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (in_flight) fifo[wr_ptr] <= mem_rd_data;
    end

    // Outputs are forced low while reset is held so nothing leaks before the
    // first reset edge or from a drain interrupted by reset.
    assign mem0_full   = rst_n && full0;
    assign mem1_full   = rst_n && full1;
    assign mem0_lock   = mem0_full;
    assign mem1_lock   = mem1_full;
    assign mem_rd_en   = rst_n && rd_en_int;
    assign mem_rd_bank = rd_bank_int;
    assign mem_rd_addr = rd_addr;
    assign wr_err      = rst_n && wr_err_q;

endmodule

// File: tb/tb_rd_drain_ctrl.sv
// Self-checking bench for rd_drain_ctrl (DEPTH = 4): SRAM model, scoreboard of
// expected output words, and directed plus randomized scenarios.
module tb_rd_drain_ctrl;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic          wr_bank = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          mem0_full, mem1_full, mem0_lock, mem1_lock;
    logic          mem_rd_en, mem_rd_bank;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          wr_err;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model: slot bitmaps, SRAM contents, expected output words.
    logic [DEPTH-1:0] m_bm [2];
    logic [DW-1:0]    m_sram [2][DEPTH];
    logic [DW-1:0]    m_q [$];
    logic             m_err, m_next, m_draining, m_drain_bank;
    int               m_addr, m_outstanding;
    logic             prev_stall;
    logic [DW-1:0]    prev_data;

    int            pop_cyc [$];
    logic [DW-1:0] pop_data [$];
    int            iss_cyc [$];
    int            iss_addr [$];
    logic          iss_bank [$];

    always #5 clk = ~clk;

    rd_drain_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .mem0_full(mem0_full), .mem1_full(mem1_full),
        .mem0_lock(mem0_lock), .mem1_lock(mem1_lock),
        .mem_rd_en(mem_rd_en), .mem_rd_bank(mem_rd_bank), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .wr_err(wr_err)
    );

    // One clock cycle: check outputs mid-cycle, advance the model, clock the DUT,
    // then return SRAM read data one cycle after the request.
    task automatic step();
        logic [DW-1:0] rd_next;
        logic          legal, pop, e0, e1;
        #1;
        e0 = rst_n && (&m_bm[0]);
        e1 = rst_n && (&m_bm[1]);
        vectors++;
        if (mem0_full !== e0 || mem0_lock !== e0) begin
            miscompares++;
            $display("FAIL mem0_full_lock cyc=%0d got %b/%b want %b", cyc, mem0_full, mem0_lock, e0);
        end
        vectors++;
        if (mem1_full !== e1 || mem1_lock !== e1) begin
            miscompares++;
            $display("FAIL mem1_full_lock cyc=%0d got %b/%b want %b", cyc, mem1_full, mem1_lock, e1);
        end
        vectors++;
        if (wr_err !== (rst_n && m_err)) begin
            miscompares++;
            $display("FAIL wr_err cyc=%0d got %b want %b", cyc, wr_err, rst_n && m_err);
        end
        pop = (out_valid === 1'b1) && (out_ready === 1'b1);
        if (!rst_n) begin
            vectors++;
            if (mem_rd_en !== 1'b0 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_outputs cyc=%0d got rd_en=%b valid=%b want 0/0", cyc, mem_rd_en, out_valid);
            end
        end else begin
            vectors++;
            if (out_valid !== 1'b0 && m_q.size() == 0) begin
                miscompares++;
                $display("FAIL spurious_valid cyc=%0d got valid=%b want 0 (no word pending)", cyc, out_valid);
            end
            if (pop && m_q.size() > 0) begin
                vectors++;
                if (out_data !== m_q[0]) begin
                    miscompares++;
                    $display("FAIL out_data cyc=%0d got %h want %h", cyc, out_data, m_q[0]);
                end
            end
            if (prev_stall) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    miscompares++;
                    $display("FAIL stall_hold cyc=%0d got %b/%h want 1/%h", cyc, out_valid, out_data, prev_data);
                end
            end
            vectors++;
            if (mem_rd_en === 1'b1) begin
                if (!m_draining || mem_rd_bank !== m_drain_bank || mem_rd_addr !== AW'(m_addr)
                    || (m_outstanding + 1 - (pop ? 1 : 0)) > 2) begin
                    miscompares++;
                    $display("FAIL rd_req cyc=%0d got bank=%b addr=%0d outst=%0d want draining=%b bank=%b addr=%0d outst<=2",
                             cyc, mem_rd_bank, mem_rd_addr, m_outstanding + 1 - (pop ? 1 : 0),
                             m_draining, m_drain_bank, m_addr);
                end
            end else if (mem_rd_en !== 1'b0) begin
                miscompares++;
                $display("FAIL rd_en_x cyc=%0d got %b want 0/1", cyc, mem_rd_en);
            end
        end

        rd_next = $urandom();
        if (!rst_n) begin
            m_bm[0] = '0; m_bm[1] = '0;
            m_q.delete();
            m_err = 1'b0; m_next = 1'b0; m_draining = 1'b0; m_drain_bank = 1'b0;
            m_addr = 0; m_outstanding = 0; prev_stall = 1'b0; prev_data = '0;
        end else begin
            legal = wr_en && !(&m_bm[wr_bank]) && !m_bm[wr_bank][wr_addr];
            m_err = wr_en && !legal;
            if (pop) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                m_outstanding--;
                pop_cyc.push_back(cyc);
                pop_data.push_back(out_data);
            end
            prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
            prev_data  = out_data;
            if (mem_rd_en === 1'b1) begin
                rd_next = m_sram[mem_rd_bank][mem_rd_addr];
                m_outstanding++;
                iss_cyc.push_back(cyc);
                iss_addr.push_back(int'(mem_rd_addr));
                iss_bank.push_back(mem_rd_bank);
                if (m_addr == DEPTH - 1) begin
                    m_bm[m_drain_bank] = '0;
                    m_draining = 1'b0;
                    m_addr = 0;
                end else begin
                    m_addr++;
                end
            end
            if (legal) begin
                m_bm[wr_bank][wr_addr]   = 1'b1;
                m_sram[wr_bank][wr_addr] = wr_data;
            end
            // Banks drain strictly alternately, each in slot order.
            if (!m_draining && (&m_bm[m_next])) begin
                for (int i = 0; i < DEPTH; i++) m_q.push_back(m_sram[m_next][i]);
                m_draining   = 1'b1;
                m_drain_bank = m_next;
                m_next       = ~m_next;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        mem_rd_data = rd_next;
        @(negedge clk);
    endtask

    task automatic write(input logic b, input int a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_bank = b; wr_addr = AW'(a); wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic clear_logs();
        pop_cyc.delete(); pop_data.delete();
        iss_cyc.delete(); iss_addr.delete(); iss_bank.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; wr_en = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({mem0_full, mem1_full, mem0_lock, mem1_lock, wr_err, out_valid, mem_rd_en} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_state got %b want 0000000",
                     {mem0_full, mem1_full, mem0_lock, mem1_lock, wr_err, out_valid, mem_rd_en});
        end
        step();
    endtask

    task automatic test_fill_drain();
        do_reset();
        out_ready = 1'b1;
        write(1'b0, 3, 32'hD3);
        write(1'b0, 1, 32'hD1);
        write(1'b0, 0, 32'hD0);
        vectors++;
        if (mem0_full !== 1'b0) begin
            miscompares++;
            $display("FAIL full_early got %b want 0", mem0_full);
        end
        write(1'b0, 2, 32'hD2);
        vectors++;
        if (mem0_full !== 1'b1 || mem0_lock !== 1'b1) begin
            miscompares++;
            $display("FAIL full_after_4th got %b/%b want 1/1", mem0_full, mem0_lock);
        end
        for (int i = 0; i < 20 && pop_data.size() < 4; i++) step();
        vectors++;
        if (pop_data.size() != 4) begin
            miscompares++;
            $display("FAIL fill_drain_count got %0d want 4", pop_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (pop_data[i] !== 32'hD0 + DW'(i) || pop_cyc[i] != pop_cyc[0] + i) begin
                    miscompares++;
                    $display("FAIL fill_drain_word%0d got %h@%0d want %h@%0d", i, pop_data[i], pop_cyc[i],
                             32'hD0 + DW'(i), pop_cyc[0] + i);
                end
            end
        end
        step();
    endtask

    task automatic test_order();
        logic [DW-1:0] b0 [DEPTH];
        logic [DW-1:0] b1 [DEPTH];
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            b1[i] = $urandom();
            write(1'b1, DEPTH - 1 - i, b1[i]);
        end
        for (int i = 0; i < 8; i++) step();
        vectors++;
        if (iss_cyc.size() != 0 || mem1_full !== 1'b1) begin
            miscompares++;
            $display("FAIL out_of_order_start got reads=%0d full1=%b want 0/1", iss_cyc.size(), mem1_full);
        end
        for (int i = 0; i < DEPTH; i++) begin
            b0[i] = $urandom();
            write(1'b0, i, b0[i]);
        end
        for (int i = 0; i < 60 && pop_data.size() < 2 * DEPTH; i++) step();
        vectors++;
        if (pop_data.size() != 2 * DEPTH || iss_cyc.size() != 2 * DEPTH) begin
            miscompares++;
            $display("FAIL order_count got pops=%0d reads=%0d want 8/8", pop_data.size(), iss_cyc.size());
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                vectors++;
                if (pop_data[i] !== b0[i] || pop_data[DEPTH + i] !== b1[DEPTH - 1 - i]) begin
                    miscompares++;
                    $display("FAIL order_word%0d got %h/%h want %h/%h", i, pop_data[i], pop_data[DEPTH + i],
                             b0[i], b1[DEPTH - 1 - i]);
                end
            end
            vectors++;
            if (iss_cyc[DEPTH] - iss_cyc[DEPTH - 1] != 2 || iss_bank[DEPTH - 1] !== 1'b0
                || iss_bank[DEPTH] !== 1'b1) begin
                miscompares++;
                $display("FAIL idle_gap got gap=%0d banks=%b%b want 2 and 01", iss_cyc[DEPTH] - iss_cyc[DEPTH - 1],
                         iss_bank[DEPTH - 1], iss_bank[DEPTH]);
            end
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] d [DEPTH];
        logic [3:0]    pattern;
        pattern = 4'b1001;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            d[i] = $urandom();
            write(1'b0, i, d[i]);
        end
        for (int k = 0; k < 80 && pop_data.size() < DEPTH; k++) begin
            out_ready = pattern[3 - (k % 4)];
            step();
        end
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        vectors++;
        if (pop_data.size() != DEPTH) begin
            miscompares++;
            $display("FAIL backpressure_count got %0d want %0d", pop_data.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                vectors++;
                if (pop_data[i] !== d[i]) begin
                    miscompares++;
                    $display("FAIL backpressure_word%0d got %h want %h", i, pop_data[i], d[i]);
                end
            end
        end
    endtask

    task automatic test_wr_err();
        logic [DW-1:0] d [DEPTH];
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) d[i] = $urandom();
        write(1'b0, 2, d[2]);
        vectors++;
        if (wr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_err_first got %b want 0", wr_err);
        end
        write(1'b0, 2, ~d[2]);
        vectors++;
        if (wr_err !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_err_dup got %b want 1", wr_err);
        end
        write(1'b0, 0, d[0]);
        vectors++;
        if (wr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_err_pulse_width got %b want 0", wr_err);
        end
        write(1'b0, 1, d[1]);
        write(1'b0, 3, d[3]);
        for (int i = 0; i < 3; i++) step();
        write(1'b0, 1, 32'hBAD0BAD0);
        vectors++;
        if (wr_err !== 1'b1 || mem0_lock !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_err_locked got %b lock=%b want 1/1", wr_err, mem0_lock);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 30 && pop_data.size() < DEPTH; i++) step();
        vectors++;
        if (pop_data.size() != DEPTH) begin
            miscompares++;
            $display("FAIL wr_err_count got %0d want %0d", pop_data.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                vectors++;
                if (pop_data[i] !== d[i]) begin
                    miscompares++;
                    $display("FAIL wr_err_word%0d got %h want %h", i, pop_data[i], d[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d [DEPTH];
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) write(1'b0, i, $urandom());
        for (int i = 0; i < 20 && pop_data.size() < 2; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        vectors++;
        if ({mem0_full, mem1_full, mem0_lock, mem1_lock, wr_err, out_valid, mem_rd_en} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs got %b want 0000000",
                     {mem0_full, mem1_full, mem0_lock, mem1_lock, wr_err, out_valid, mem_rd_en});
        end
        for (int i = 0; i < 8; i++) step();
        clear_logs();
        for (int i = 0; i < DEPTH; i++) begin
            d[i] = $urandom();
            write(1'b0, i, d[i]);
        end
        for (int i = 0; i < 20 && pop_data.size() < DEPTH; i++) step();
        vectors++;
        if (pop_data.size() != DEPTH || iss_addr.size() == 0 || iss_addr[0] != 0) begin
            miscompares++;
            $display("FAIL reset_mid_restart got pops=%0d first_addr=%0d want %0d/0", pop_data.size(),
                     iss_addr.size() ? iss_addr[0] : -1, DEPTH);
        end else begin
            vectors++;
            if (pop_data[0] !== d[0] || pop_data[DEPTH - 1] !== d[DEPTH - 1]) begin
                miscompares++;
                $display("FAIL reset_mid_data got %h..%h want %h..%h", pop_data[0], pop_data[DEPTH - 1],
                         d[0], d[DEPTH - 1]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            wr_en     = ($urandom_range(0, 1) == 1);
            wr_bank   = $urandom_range(0, 1) == 1;
            wr_addr   = AW'($urandom_range(0, DEPTH - 1));
            wr_data   = $urandom();
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        wr_en = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && (m_q.size() != 0 || m_draining); i++) step();
        step();
        vectors++;
        if (m_q.size() != 0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL random_flush got pending=%0d valid=%b want 0/0", m_q.size(), out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_order();
        test_backpressure();
        test_wr_err();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rd_drain_ctrl.md
RD_DRAIN_CTRL -- requirements
Module: rd_drain_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entries per bank (power of two, >=2).
REQ-002 SHALL have parameter DW, default 32, data width; AW = log2(DEPTH).
REQ-003 SHALL have clk  input  1  clock; all logic on the rising edge.
REQ-004 SHALL have rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have wr_en  input  1  one entry written to the SRAM this cycle.
REQ-006 SHALL have wr_bank  input  1  bank of that write (0 = mem0, 1 = mem1).
REQ-007 SHALL have wr_addr  input  AW  slot (reorder tag) of that write.
REQ-008 SHALL have mem0_full, mem1_full  output  1 each  bank has all DEPTH slots written.
REQ-009 SHALL have mem0_lock, mem1_lock  output  1 each  bank owned by the read side; writer must not target it.
REQ-010 SHALL have mem_rd_en  output  1, mem_rd_bank  output  1, mem_rd_addr  output  AW  SRAM read request.
REQ-011 SHALL have mem_rd_data  input  DW  SRAM read data, valid exactly 1 cycle after mem_rd_en.
REQ-012 SHALL have out_valid  output  1, out_ready  input  1, out_data  output  DW  in-order output stream.
REQ-013 SHALL have wr_err  output  1  one-cycle pulse on an illegal write.

Function
REQ-014 SHALL keep a registered DEPTH-bit slot bitmap per bank; a legal write sets bit wr_addr of bank wr_bank at the clock edge.
REQ-015 SHALL drive memX_full = AND of bank X bitmap (full visible the cycle after the final write); memX_lock SHALL equal memX_full.
REQ-016 SHALL treat a write as illegal when the target bank is locked or the target bit is already set: bitmap unchanged, wr_err = 1 the next cycle.
REQ-017 SHALL implement read FSM states IDLE, RD0, RD1 plus a next_bank pointer (reset 0).
REQ-018 IDLE -> RDn when mem<next_bank>_full; the other bank's full status SHALL NOT start a drain out of order.
REQ-019 In RDn SHALL issue reads for addr 0,1,...,DEPTH-1 of bank n, in ascending order, one per issuing cycle.
REQ-020 SHALL hold a 2-entry output FIFO; a read SHALL issue only if (FIFO count + reads in flight - pop this cycle) < 2, giving one word per cycle when out_ready is held high.
REQ-021 mem_rd_data SHALL be written into the output FIFO in the cycle it is valid; data order SHALL equal address order.
REQ-022 out_valid = FIFO non-empty; out_data = FIFO head; pop on out_valid && out_ready; out_data/out_valid SHALL be stable while out_valid && !out_ready.
REQ-023 On the edge that issues addr DEPTH-1, SHALL clear bank n bitmap (full and lock deassert next cycle), toggle next_bank, and return to IDLE.
REQ-024 The transition RDn -> IDLE -> RD(1-n) SHALL take 1 cycle in IDLE if the other bank is already full; no read issues in IDLE.
REQ-025 A legal write to bank n in the cycle its lock first deasserts SHALL be accepted.
REQ-026 Simultaneous legal write to one bank and drain of the other SHALL both proceed.

Reset
REQ-027 On rst_n = 0 at a clock edge: bitmaps = 0, state = IDLE, next_bank = 0, FIFO empty, in-flight = 0.
REQ-028 During reset and the first cycle after it: memX_full = 0, memX_lock = 0, mem_rd_en = 0, out_valid = 0, wr_err = 0.
REQ-029 Reset asserted mid-drain SHALL discard all buffered and in-flight data; no out_valid after reset until a new bank fills.

Verification (DEPTH = 4)
REQ-030 Write bank0 slots 3,1,0,2 (data 0xD3,0xD1,0xD0,0xD2), out_ready = 1 -> mem0_full/lock high the cycle after the 4th write; out_data 0xD0,0xD1,0xD2,0xD3 on 4 consecutive cycles; mem0_lock low the cycle after addr 3 is read.
REQ-031 Fill bank1 first, then bank0 -> nothing drained until bank0 full; bank0 drains fully, then bank1 after 1 IDLE cycle.
REQ-032 Drain with out_ready toggling 1,0,0,1,... -> no data lost or duplicated, out_data stable while stalled, at most 2 reads ahead of pops.
REQ-033 Write bank0 slot 2 twice; then write to locked bank0 -> wr_err pulses once per illegal write, bitmap and output stream unaffected.
REQ-034 Assert rst_n = 0 after 2 words of a drain -> all outputs 0 next cycle; refill bank0 -> drain restarts at addr 0.
